tofed_arb_2of5: RTL and testbench

Round-robin scheduler that shares one serial 2-of-5 checker between NREQ requesters. Each requester offers a 5-bit fbibble on a valid/ready handshake. The block grants one requester, shifts the fbibble MSB-first through the checker, returns a tagged error result, and keeps per-requester saturating error counts. It sits between the parallel fbibble sources and the serial TOFED checking datapath.

---
 rtl/tofed_arb_2of5_pkg.sv | 15 +
 rtl/tofed_serial_check_2of5.sv | 30 +++
 rtl/tofed_arb_2of5.sv | 134 +++++++++++++
 tb/tb_tofed_arb_2of5.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tofed_arb_2of5_pkg.sv
// rtl/tofed_arb_2of5_pkg.sv - shared 2-of-5 fbibble constants, bool type and arbiter state encoding
package SerialTOFEDDefs_2of5;

  localparam int FBIBBLE_SIZE   = 5;
  localparam int ONESPERFBIBBLE = 2;

  typedef logic bool_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SHIFT,
    ARB_DONE
  } arb_state_t;

endpackage

// File: rtl/tofed_serial_check_2of5.sv
// rtl/tofed_serial_check_2of5.sv - serial ones counter flagging fbibbles without exactly ONESPERFBIBBLE ones
module tofed_serial_check_2of5
  import SerialTOFEDDefs_2of5::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  bool_t start,
  input  bool_t bit_valid,
  input  logic  bit_in,
  output bool_t err
);

  localparam int CNT_W = $clog2(ONESPERFBIBBLE + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ONESPERFBIBBLE + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (bit_valid && bit_in && (cnt_q != CNT_SAT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err = (cnt_q != CNT_W'(ONESPERFBIBBLE));

endmodule

// File: rtl/tofed_arb_2of5.sv
// rtl/tofed_arb_2of5.sv - round-robin sharing of one serial 2-of-5 checker among NREQ requesters
// Error counters are built only when TOFED_ERRCNT_EN is defined; otherwise err_cnt reads 0.
module tofed_arb_2of5
  import SerialTOFEDDefs_2of5::*;
#(
  parameter  int NREQ     = 2,
  parameter  int ERRCNT_W = 8,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*FBIBBLE_SIZE-1:0] req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rsp_valid,
  output logic [IDW-1:0]               rsp_id,
  output logic                         rsp_err,
  input  logic                         clr_cnt,
  output logic [NREQ*ERRCNT_W-1:0]     err_cnt
);

  arb_state_t              state_q, state_d;
  logic [IDW-1:0]          last_grant_q, grant_q, grant_d;
  logic [FBIBBLE_SIZE-1:0] data_q;
  logic [2:0]              bit_idx_q;
  logic [IDW-1:0]          rsp_id_q;
  logic                    rsp_err_q;
  logic                    any_valid;
  bool_t                   start, bit_valid, chk_err;
  int                      idx;

  // First valid requester after last_grant, wrapping around.
  always_comb begin
    grant_d   = last_grant_q;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant_d   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    start     = 1'b0;
    bit_valid = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          req_ready[grant_d] = 1'b1;
          start              = 1'b1;
          state_d            = ARB_SHIFT;
        end
      end
      ARB_SHIFT: begin
        bit_valid = 1'b1;
        if (bit_idx_q == 3'd4) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        rsp_valid = 1'b1;
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      grant_q      <= '0;
      data_q       <= '0;
      bit_idx_q    <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && any_valid) begin
        grant_q <= grant_d;
        data_q  <= req_data[int'(grant_d)*FBIBBLE_SIZE +: FBIBBLE_SIZE];
      end
      if (state_q == ARB_SHIFT) begin
        bit_idx_q <= (bit_idx_q == 3'd4) ? 3'd0 : bit_idx_q + 3'd1;
      end
      if (state_q == ARB_DONE) begin
        last_grant_q <= grant_q;
        rsp_id_q     <= grant_q;
        rsp_err_q    <= chk_err;
      end
    end
  end

  // Result fields hold the previous response outside ARB_DONE.
  assign rsp_id  = (state_q == ARB_DONE) ? grant_q : rsp_id_q;
  assign rsp_err = (state_q == ARB_DONE) ? chk_err : rsp_err_q;

  tofed_serial_check_2of5 u_check (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (data_q[3'd4 - bit_idx_q]),
    .err       (chk_err)
  );

`ifdef TOFED_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt_q [NREQ];

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (state_q == ARB_DONE && chk_err && (cnt_q[grant_q] != '1)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + ERRCNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    assign err_cnt[gi*ERRCNT_W +: ERRCNT_W] = cnt_q[gi];
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_tofed_arb_2of5.sv
// tb/tb_tofed_arb_2of5.sv - directed scoreboard bench for tofed_arb_2of5 (TOFED_ERRCNT_EN aware)
module tb_tofed_arb_2of5;

  localparam int NREQ = 2;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*5-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_err;
  logic              clr_cnt = 1'b0;
  logic [NREQ*CW-1:0] err_cnt;

  typedef struct {
    int   id;
    logic err;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   a0, a1, a2, a3, dummy;

  tofed_arb_2of5 #(.NREQ(NREQ), .ERRCNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ce(input int v);
`ifdef TOFED_ERRCNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic chk_cnt(input string nm, input int c0, input int c1);
    chk({nm, "_cnt0"}, 32'(err_cnt[0 +: CW]), ce(c0));
    chk({nm, "_cnt1"}, 32'(err_cnt[CW +: CW]), ce(c1));
  endtask

  // Offer data, wait for the one-hot grant, record the expected response.
  task automatic send(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                      input int g, input logic e, output int acc);
    req_valid = v;
    req_data  = {d1, d0};
    acc       = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    if (req_ready == '0) begin
      chk("grant_timeout", 32'(req_ready), 32'(1 << g));
    end else begin
      chk("req_ready", 32'(req_ready), 32'(1 << g));
      acc = cyc;
      exp_q.push_back('{g, e, cyc + 6});
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp got id %0d err %0d want none (cycle %0d)", rsp_id, rsp_err, cyc);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(x.id));
        chk("rsp_err", 32'(rsp_err), 32'(x.err));
        chk("rsp_cycle", cyc, x.cyc);
      end
    end
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk_cnt("rst", 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_cnt", 32'(err_cnt), 0);
    end
    @(posedge clk); #1;

    // Single requester 0, valid fbibble.
    send(2'b01, 5'b01100, 5'b00000, 0, 1'b0, dummy);
    req_valid = '0;
    wait_idle();
    chk_cnt("t2", 0, 0);

    // Single requester 1, three ones.
    send(2'b10, 5'b00000, 5'b11100, 1, 1'b1, dummy);
    req_valid = '0;
    wait_idle();
    chk_cnt("t3", 0, 1);
    @(negedge clk);
    chk("hold_rsp_id", 32'(rsp_id), 1);
    chk("hold_rsp_err", 32'(rsp_err), 1);
    @(posedge clk); #1;

    // Both valid continuously: alternate grants at 7-cycle spacing.
    send(2'b11, 5'b00000, 5'b10001, 0, 1'b1, a0);
    send(2'b11, 5'b00000, 5'b10001, 1, 1'b0, a1);
    send(2'b11, 5'b00000, 5'b10001, 0, 1'b1, a2);
    send(2'b11, 5'b00000, 5'b10001, 1, 1'b0, a3);
    req_valid = '0;
    chk("spacing_01", a1 - a0, 7);
    chk("spacing_12", a2 - a1, 7);
    chk("spacing_23", a3 - a2, 7);
    wait_idle();
    chk_cnt("t4", 2, 1);

    // Clear, then saturate requester 0.
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk_cnt("clr", 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(2'b01, 5'b00000, 5'b00000, 0, 1'b1, dummy);
    req_valid = '0;
    wait_idle();
    chk_cnt("sat", 3, 0);

    // Sixth error with clr_cnt in its ARB_DONE cycle.
    send(2'b01, 5'b00000, 5'b00000, 0, 1'b1, dummy);
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(negedge clk);
    chk("done_with_clr", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk_cnt("clr_wins", 0, 0);
    @(posedge clk); #1;

    // Put an error on requester 1 so the reset clear is observable.
    send(2'b10, 5'b00000, 5'b11111, 1, 1'b1, dummy);
    req_valid = '0;
    wait_idle();
    chk_cnt("pre_rst", 0, 1);

    // Abort a requester 1 transfer in its third shift cycle.
    send(2'b10, 5'b00000, 5'b01010, 1, 1'b0, dummy);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 0);
      chk("abort_ready", 32'(req_ready), 0);
    end
    chk_cnt("abort", 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(2'b11, 5'b01100, 5'b10001, 0, 1'b0, dummy);
    req_valid = '0;
    wait_idle();

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
